// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential ALU responder.
package seq_alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_alu_step.sv
// One iteration of shift-add multiply or restoring divide (combinational).
// MUL: acc = {partial product high, multiplier/low product}; operand = multiplicand.
// DIV: acc = {remainder, dividend/quotient}; operand = divisor.
// For DIV the quotient bit is returned separately; the LSB of acc_next is 0.
module seq_alu_step
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]         op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               qbit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] rem_wide;

  // Select multiply or divide iteration
  always_comb begin
    acc_next = acc;
    qbit     = 1'b0;
    sum      = '0;
    r_sh     = '0;
    rem_wide = '0;
    if (op == OP_DIV) begin
      r_sh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      qbit     = (r_sh >= {1'b0, operand});
      rem_wide = qbit ? (r_sh - {1'b0, operand}) : r_sh;
      acc_next = {WIDTH'(rem_wide), acc[WIDTH-2:0], 1'b0};
    end else begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/seq_alu_responder.sv
// Multi-cycle ALU responder on a Start/Done handshake.
// ADD/SUB complete in one cycle; MUL/DIV iterate WIDTH times (data-independent).
// Optional macro SEQ_ALU_HI_EN adds Result_Hi (upper product / remainder).
import seq_alu_pkg::*;

module seq_alu_responder #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ALUOP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Done,
  output logic             Busy
`ifdef SEQ_ALU_HI_EN
  ,
  output logic [WIDTH-1:0] Result_Hi
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned ACC_W = 2 * WIDTH;

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  alu_op_t          op_q;
  logic [WIDTH-1:0] opnd;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] step_acc;
  logic [ACC_W-1:0] acc_d;
  logic             step_qbit;
  logic             start_fast;
  logic             start_iter;
  logic             last_iter;
  logic [WIDTH-1:0] fast_res;

  seq_alu_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_q),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (step_acc),
    .qbit     (step_qbit)
  );

  assign acc_d = {step_acc[ACC_W-1:1], step_acc[0] | step_qbit};

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          if (ALUOP == OP_ADD || ALUOP == OP_SUB) state_d = ST_DONE;
          else                                    state_d = ST_RUN;
        end
      end
      ST_RUN:  if (cnt == CNT_W'(WIDTH - 1)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath control decode
  always_comb begin
    start_fast = 1'b0;
    start_iter = 1'b0;
    last_iter  = 1'b0;
    fast_res   = (ALUOP == OP_SUB) ? (A - B) : (A + B);
    if (state == ST_IDLE && Start) begin
      if (ALUOP == OP_ADD || ALUOP == OP_SUB) start_fast = 1'b1;
      else                                    start_iter = 1'b1;
    end
    if (state == ST_RUN && cnt == CNT_W'(WIDTH - 1)) last_iter = 1'b1;
  end

  // Operand latch, iteration registers and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt       <= '0;
      op_q      <= OP_ADD;
      opnd      <= '0;
      acc       <= '0;
      Result    <= '0;
      Done      <= 1'b0;
      Busy      <= 1'b0;
`ifdef SEQ_ALU_HI_EN
      Result_Hi <= '0;
`endif
    end else begin
      Done <= (state_d == ST_DONE);
      Busy <= (state_d != ST_IDLE);
      if (start_fast) begin
        Result    <= fast_res;
`ifdef SEQ_ALU_HI_EN
        Result_Hi <= '0;
`endif
      end
      if (start_iter) begin
        op_q <= alu_op_t'(ALUOP);
        cnt  <= '0;
        if (ALUOP == OP_MUL) begin
          opnd <= A;
          acc  <= {{WIDTH{1'b0}}, B};
        end else begin
          opnd <= B;
          acc  <= {{WIDTH{1'b0}}, A};
        end
      end
      if (state == ST_RUN) begin
        acc <= acc_d;
        cnt <= cnt + CNT_W'(1);
        if (last_iter) begin
          Result    <= acc_d[WIDTH-1:0];
`ifdef SEQ_ALU_HI_EN
          Result_Hi <= acc_d[ACC_W-1:WIDTH];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu_responder.sv
// Bench for seq_alu_responder: latency/arith model plus directed vectors.
module tb_seq_alu_responder;
  import seq_alu_pkg::*;

  localparam int unsigned W = 16;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Start;
  logic [1:0]   ALUOP;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Result;
  logic         Done;
  logic         Busy;
`ifdef SEQ_ALU_HI_EN
  logic [W-1:0] Result_Hi;
`endif

  always #5 Clock = ~Clock;

  seq_alu_responder #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .ALUOP     (ALUOP),
    .A         (A),
    .B         (B),
    .Result    (Result),
    .Done      (Done),
    .Busy      (Busy)
`ifdef SEQ_ALU_HI_EN
    ,
    .Result_Hi (Result_Hi)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation definitions
  task automatic calc(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      output logic [W-1:0] lo, output logic [W-1:0] hi);
    logic [2*W-1:0] prod;
    prod = '0;
    case (op)
      2'd0: begin lo = W'(a + b); hi = '0; end
      2'd1: begin lo = W'(a - b); hi = '0; end
      2'd2: begin prod = (2*W)'(a) * (2*W)'(b); lo = prod[W-1:0]; hi = prod[2*W-1:W]; end
      default: begin
        if (b == '0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endtask

  // Model: 0 idle, 1 computing (m_k edges to go), 2 done cycle
  int           m_phase = 0;
  int           m_k = 0;
  logic [W-1:0] m_res, m_hi, p_res, p_hi;
  bit           model_valid = 1'b0;
  bit           m_was_reset = 1'b0;

  always @(posedge Clock) begin
    m_was_reset = 1'b0;
    if (Reset) begin
      m_phase = 0; m_res = '0; m_hi = '0; model_valid = 1'b1; m_was_reset = 1'b1;
    end else if (model_valid) begin
      case (m_phase)
        2: m_phase = 0;
        1: begin
          m_k--;
          if (m_k == 0) begin m_res = p_res; m_hi = p_hi; m_phase = 2; end
        end
        default: if (Start) begin
          calc(ALUOP, A, B, p_res, p_hi);
          if (ALUOP < 2'd2) begin m_res = p_res; m_hi = p_hi; m_phase = 2; end
          else begin m_k = W; m_phase = 1; end
        end
      endcase
    end
  end

  // Cycle-by-cycle comparison on the falling edge
  logic [W-1:0] prev_res;
  always @(negedge Clock) begin
    if (model_valid) begin
      chk("done", 32'(Done), 32'(m_phase == 2));
      chk("busy", 32'(Busy), 32'(m_phase != 0));
      chk("result", 32'(Result), 32'(m_res));
`ifdef SEQ_ALU_HI_EN
      chk("result_hi", 32'(Result_Hi), 32'(m_hi));
`endif
      if (!Done && !m_was_reset) chk("result_hold", 32'(Result), 32'(prev_res));
      prev_res = Result;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Issue one op from idle, measure latency, pin DUT and model to literals
  task automatic do_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int exp_lat,
                       input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
    int lat;
    ALUOP = op; A = a; B = b; Start = 1'b1;
    tick();
    Start = 1'b0; ALUOP = ~op; A = ~a; B = b + 16'd3;
    lat = 1;
    while (!Done && lat < 40) begin
      tick();
      lat++;
    end
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({name, "_lo"}, 32'(Result), 32'(exp_lo));
    chk({name, "_lo_model"}, 32'(m_res), 32'(exp_lo));
    chk({name, "_hi_model"}, 32'(m_hi), 32'(exp_hi));
`ifdef SEQ_ALU_HI_EN
    chk({name, "_hi"}, 32'(Result_Hi), 32'(exp_hi));
`endif
    tick();
  endtask

  initial begin
    int dones;
    int k;
    Reset = 1'b1; Start = 1'b0; ALUOP = 2'd0; A = '0; B = '0;
    tick(); tick();
    chk("reset_result", 32'(Result), 32'h0);
    chk("reset_done", 32'(Done), 32'h0);
    chk("reset_busy", 32'(Busy), 32'h0);
    Reset = 1'b0;
    tick();

    do_op("add_wrap", 2'd0, 16'hFFFF, 16'h0001, 1, 16'h0000, 16'h0000);
    do_op("sub_wrap", 2'd1, 16'h0000, 16'h0001, 1, 16'hFFFF, 16'h0000);
    do_op("mul", 2'd2, 16'd300, 16'd250, 17, 16'h24F8, 16'h0001);
    do_op("div", 2'd3, 16'd1000, 16'd7, 17, 16'd142, 16'd6);
    do_op("div0", 2'd3, 16'd1234, 16'd0, 17, 16'hFFFF, 16'd1234);
    do_op("mul_max", 2'd2, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 16'hFFFE);

    // Reset in the middle of MUL 3*5: no Done, outputs cleared
    ALUOP = 2'd2; A = 16'd3; B = 16'd5; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rst_mid_result", 32'(Result), 32'h0);
    chk("rst_mid_busy", 32'(Busy), 32'h0);
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (Done) dones++;
    end
    chk("rst_mid_no_done", 32'(dones), 32'h0);

    // Back-to-back ADD then MUL with Start held high
    ALUOP = 2'd0; A = 16'd10; B = 16'd20; Start = 1'b1;
    tick();
    chk("b2b_add_done", 32'(Done), 32'h1);
    chk("b2b_add_res", 32'(Result), 32'd30);
    ALUOP = 2'd2; A = 16'd300; B = 16'd250;
    k = 0;
    do begin
      tick();
      k++;
    end while (!Done && k < 40);
    chk("b2b_gap", 32'(k), 32'd18);
    chk("b2b_mul_res", 32'(Result), 32'h24F8);
    Start = 1'b0;
    tick();

    // Start held high while operands churn every cycle
    Start = 1'b1;
    for (int i = 0; i < 90; i++) begin
      ALUOP = 2'($urandom_range(0, 3));
      A = 16'($urandom);
      B = (i % 7 == 0) ? 16'd0 : 16'($urandom);
      tick();
    end
    Start = 1'b0;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
